// File: rtl/memory_bus_arbiter_if.sv
// Requester-side handshakes and MemoryBus slot signals shared by the arbiter.
// The master modport is the arbiter's view; slave is the requesters/memory view.
interface memory_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic                      bus_request_busy;
    logic                      bus_req_push;
    logic [1:0]                bus_req_type;
    logic [ID_W-1:0]           bus_req_source;
    logic [ADDR_W-1:0]         bus_req_addr;
    logic [DATA_W-1:0]         bus_req_payload;
    logic                      bus_response_busy;
    logic [1:0]                bus_rsp_type;
    logic [ID_W-1:0]           bus_rsp_source;
    logic [DATA_W-1:0]         bus_rsp_payload;
    logic                      bus_rsp_pop;
    logic                      err_timeout;
    logic                      err_unexpected;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  bus_request_busy, bus_response_busy, bus_rsp_type, bus_rsp_source, bus_rsp_payload,
        output req_ready, rsp_valid, rsp_data,
        output bus_req_push, bus_req_type, bus_req_source, bus_req_addr, bus_req_payload,
        output bus_rsp_pop, err_timeout, err_unexpected
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output bus_request_busy, bus_response_busy, bus_rsp_type, bus_rsp_source, bus_rsp_payload,
        input  req_ready, rsp_valid, rsp_data,
        input  bus_req_push, bus_req_type, bus_req_source, bus_req_addr, bus_req_payload,
        input  bus_rsp_pop, err_timeout, err_unexpected
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one MemoryBus request/response slot pair between
// NUM_REQ requesters; one transaction in flight, reads held until delivered.
module memory_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    memory_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RESP = 2'd2, DELIVER = 2'd3} state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0]      T_READ  = 2'd0;
    localparam logic [1:0]      T_WRITE = 2'd1;
    localparam logic [1:0]      T_RRESP = 2'd2;

    state_t              state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     grant_r;
    logic                write_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [7:0]          cnt_r;
    logic [NUM_REQ-1:0]  req_ready_r;
    logic [NUM_REQ-1:0]  rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                push_r;
    logic [1:0]          req_type_r;
    logic [ID_W-1:0]     req_source_r;
    logic [ADDR_W-1:0]   req_addr_r;
    logic [DATA_W-1:0]   req_payload_r;
    logic                pop_r;
    logic                err_to_r;
    logic                err_ux_r;
    logic [ID_W:0]       pick_s;
    logic [ID_W-1:0]     pick_idx_s;

    // First set bit at or above ptr with wrap; returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int            idx;
        res = {(ID_W + 1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            res = v[idx] ? {1'b1, ID_W'(idx)} : res;
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] g);
        return (g == LAST_ID) ? {ID_W{1'b0}} : g + ID_W'(1);
    endfunction

    // Requester still showing valid in its accept cycle is masked so it is not re-granted.
    always_comb begin
        pick_s     = rr_pick(bus.req_valid & ~req_ready_r, rr_ptr_r);
        pick_idx_s = pick_s[ID_W-1:0];
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            rr_ptr_r      <= {ID_W{1'b0}};
            grant_r       <= {ID_W{1'b0}};
            write_r       <= 1'b0;
            addr_r        <= {ADDR_W{1'b0}};
            wdata_r       <= {DATA_W{1'b0}};
            cnt_r         <= 8'd0;
            req_ready_r   <= {NUM_REQ{1'b0}};
            rsp_valid_r   <= {NUM_REQ{1'b0}};
            rsp_data_r    <= {DATA_W{1'b0}};
            push_r        <= 1'b0;
            req_type_r    <= 2'd0;
            req_source_r  <= {ID_W{1'b0}};
            req_addr_r    <= {ADDR_W{1'b0}};
            req_payload_r <= {DATA_W{1'b0}};
            pop_r         <= 1'b0;
            err_to_r      <= 1'b0;
            err_ux_r      <= 1'b0;
        end else begin
            push_r      <= 1'b0;
            pop_r       <= 1'b0;
            req_ready_r <= {NUM_REQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (pick_s[ID_W]) begin
                        grant_r <= pick_idx_s;
                        write_r <= bus.req_write[pick_idx_s];
                        addr_r  <= bus.req_addr[int'(pick_idx_s) * ADDR_W +: ADDR_W];
                        wdata_r <= bus.req_wdata[int'(pick_idx_s) * DATA_W +: DATA_W];
                        state_r <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (!bus.bus_request_busy) begin
                        push_r        <= 1'b1;
                        req_type_r    <= write_r ? T_WRITE : T_READ;
                        req_source_r  <= grant_r;
                        req_addr_r    <= addr_r;
                        req_payload_r <= write_r ? wdata_r : {DATA_W{1'b0}};
                        req_ready_r   <= NUM_REQ'(1) << grant_r;
                        if (write_r) begin
                            state_r  <= IDLE;
                            rr_ptr_r <= next_id(grant_r);
                        end else begin
                            state_r <= WAIT_RESP;
                            cnt_r   <= 8'd0;
                        end
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT_RESP: begin
                    // The slot stays busy in the cycle our pop is visible; skip it to avoid a double pop.
                    if (bus.bus_response_busy && !pop_r && (bus.bus_rsp_type == T_RRESP)) begin
                        pop_r                <= 1'b1;
                        rsp_data_r           <= bus.bus_rsp_payload;
                        rsp_valid_r          <= NUM_REQ'(1) << grant_r;
                        state_r              <= DELIVER;
                    end else begin
                        if (bus.bus_response_busy && !pop_r) begin
                            pop_r    <= 1'b1;
                            err_ux_r <= 1'b1;
                        end else begin
                            pop_r <= 1'b0;
                        end
                        if (cnt_r == TO_LAST) begin
                            err_to_r <= 1'b1;
                            state_r  <= IDLE;
                            rr_ptr_r <= next_id(grant_r);
                        end else begin
                            cnt_r   <= cnt_r + 8'd1;
                            state_r <= WAIT_RESP;
                        end
                    end
                end
                DELIVER: begin
                    if (bus.rsp_ready[grant_r]) begin
                        rsp_valid_r <= {NUM_REQ{1'b0}};
                        state_r     <= IDLE;
                        rr_ptr_r    <= next_id(grant_r);
                    end else begin
                        state_r <= DELIVER;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_r;
    assign bus.rsp_valid       = rsp_valid_r;
    assign bus.rsp_data        = rsp_data_r;
    assign bus.bus_req_push    = push_r;
    assign bus.bus_req_type    = req_type_r;
    assign bus.bus_req_source  = req_source_r;
    assign bus.bus_req_addr    = req_addr_r;
    assign bus.bus_req_payload = req_payload_r;
    assign bus.bus_rsp_pop     = pop_r;
    assign bus.err_timeout     = err_to_r;
    assign bus.err_unexpected  = err_ux_r;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: write, read round trip, fairness,
// backpressure, timeout and stray-response scenarios with hand-computed values.
module tb_memory_bus_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    bit   ok;

    memory_bus_arbiter_if #(.NUM_REQ(4), .ID_W(2), .ADDR_W(32), .DATA_W(32)) bus ();

    memory_bus_arbiter #(
        .NUM_REQ(4), .ID_W(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus.req_write[i]         = wr;
        bus.req_addr[i*32 +: 32]  = a;
        bus.req_wdata[i*32 +: 32] = d;
    endtask

    task automatic wait_push(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.bus_req_push) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_write = 4'b0000;
        bus.req_addr  = 128'd0;
        bus.req_wdata = 128'd0;
        bus.rsp_ready = 4'b0000;
        bus.bus_request_busy  = 1'b0;
        bus.bus_response_busy = 1'b0;
        bus.bus_rsp_type      = 2'd0;
        bus.bus_rsp_source    = 2'd0;
        bus.bus_rsp_payload   = 32'd0;
        tick();
        tick();
        check_eq("rst_push", bus.bus_req_push, 1'b0);
        check_eq("rst_ready", bus.req_ready, 4'b0000);
        check_eq("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        check_eq("rst_pop", bus.bus_rsp_pop, 1'b0);
        check_eq("rst_errs", {bus.err_timeout, bus.err_unexpected}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Single write from requester 1
        set_req(1, 1'b1, 32'h100, 32'hDEAD);
        bus.req_valid = 4'b0010;
        tick();
        check_eq("wr_no_push_c1", bus.bus_req_push, 1'b0);
        tick();
        check_eq("wr_push", bus.bus_req_push, 1'b1);
        check_eq("wr_type", bus.bus_req_type, 2'd1);
        check_eq("wr_source", bus.bus_req_source, 2'd1);
        check_eq("wr_addr", bus.bus_req_addr, 32'h100);
        check_eq("wr_payload", bus.bus_req_payload, 32'hDEAD);
        check_eq("wr_ready", bus.req_ready, 4'b0010);
        tick();
        check_eq("wr_push_drop", bus.bus_req_push, 1'b0);
        check_eq("wr_ready_drop", bus.req_ready, 4'b0000);
        bus.req_valid = 4'b0000;
        tick();
        tick();
        check_eq("wr_no_regrant", bus.bus_req_push, 1'b0);

        // Read round trip from requester 2
        set_req(2, 1'b0, 32'h40, 32'hFFFF);
        bus.req_valid = 4'b0100;
        tick();
        tick();
        check_eq("rd_push", bus.bus_req_push, 1'b1);
        check_eq("rd_type", bus.bus_req_type, 2'd0);
        check_eq("rd_source", bus.bus_req_source, 2'd2);
        check_eq("rd_addr", bus.bus_req_addr, 32'h40);
        check_eq("rd_payload", bus.bus_req_payload, 32'h0);
        check_eq("rd_ready", bus.req_ready, 4'b0100);
        bus.req_valid = 4'b0000;
        tick();
        tick();
        bus.bus_response_busy = 1'b1;
        bus.bus_rsp_type      = 2'd2;
        bus.bus_rsp_payload   = 32'h1234;
        tick();
        check_eq("rd_pop", bus.bus_rsp_pop, 1'b1);
        check_eq("rd_rsp_valid", bus.rsp_valid, 4'b0100);
        check_eq("rd_rsp_data", bus.rsp_data, 32'h1234);
        tick();
        check_eq("rd_pop_once", bus.bus_rsp_pop, 1'b0);
        bus.bus_response_busy = 1'b0;
        tick();
        check_eq("rd_rsp_hold", bus.rsp_valid, 4'b0100);
        check_eq("rd_data_hold", bus.rsp_data, 32'h1234);
        bus.rsp_ready = 4'b0100;
        tick();
        check_eq("rd_rsp_done", bus.rsp_valid, 4'b0000);
        bus.rsp_ready = 4'b0000;

        // Fairness from reset: all four writing continuously
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h1000 + i, 32'hA0 + i);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_push(ok);
            check_eq("rr_push_seen", ok, 1'b1);
            check_eq("rr_source", bus.bus_req_source, k % 4);
            check_eq("rr_addr", bus.bus_req_addr, 32'h1000 + (k % 4));
            check_eq("rr_ready", bus.req_ready, 4'b0001 << (k % 4));
        end
        bus.req_valid = 4'b0000;
        tick();

        // Backpressure: request slot busy for 5 cycles in ISSUE
        bus.bus_request_busy = 1'b1;
        set_req(3, 1'b1, 32'h300, 32'h33);
        bus.req_valid = 4'b1000;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("bp_no_push", bus.bus_req_push, 1'b0);
            check_eq("bp_no_ready", bus.req_ready, 4'b0000);
        end
        bus.bus_request_busy = 1'b0;
        tick();
        check_eq("bp_push", bus.bus_req_push, 1'b1);
        check_eq("bp_source", bus.bus_req_source, 2'd3);
        check_eq("bp_payload", bus.bus_req_payload, 32'h33);
        check_eq("bp_ready", bus.req_ready, 4'b1000);
        bus.req_valid = 4'b0000;
        tick();

        // Timeout: read from 0 never answered, write from 1 waiting behind it
        set_req(0, 1'b0, 32'h80, 32'h0);
        set_req(1, 1'b1, 32'h180, 32'h11);
        bus.req_valid = 4'b0011;
        tick();
        tick();
        check_eq("to_push_src", {bus.bus_req_push, bus.bus_req_source}, 3'b100);
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 7; c++) tick();
        check_eq("to_not_yet", bus.err_timeout, 1'b0);
        tick();
        check_eq("to_err", bus.err_timeout, 1'b1);
        check_eq("to_no_rsp", bus.rsp_valid, 4'b0000);
        tick();
        tick();
        check_eq("to_next_push", bus.bus_req_push, 1'b1);
        check_eq("to_next_src", bus.bus_req_source, 2'd1);
        check_eq("to_next_type", bus.bus_req_type, 2'd1);
        bus.req_valid = 4'b0000;
        tick();

        // Stray response then a valid one, requester 2 reading
        set_req(2, 1'b0, 32'h44, 32'h0);
        bus.req_valid = 4'b0100;
        tick();
        tick();
        check_eq("st_push_src", {bus.bus_req_push, bus.bus_req_source}, 3'b110);
        bus.req_valid = 4'b0000;
        bus.bus_response_busy = 1'b1;
        bus.bus_rsp_type      = 2'd1;
        bus.bus_rsp_payload   = 32'hBAD;
        tick();
        check_eq("st_pop", bus.bus_rsp_pop, 1'b1);
        check_eq("st_err", bus.err_unexpected, 1'b1);
        check_eq("st_no_rsp", bus.rsp_valid, 4'b0000);
        tick();
        check_eq("st_pop_once", bus.bus_rsp_pop, 1'b0);
        bus.bus_rsp_type    = 2'd2;
        bus.bus_rsp_payload = 32'h5678;
        tick();
        check_eq("st_good_pop", bus.bus_rsp_pop, 1'b1);
        check_eq("st_rsp_valid", bus.rsp_valid, 4'b0100);
        check_eq("st_rsp_data", bus.rsp_data, 32'h5678);
        check_eq("st_err_sticky", bus.err_unexpected, 1'b1);
        bus.bus_response_busy = 1'b0;
        bus.rsp_ready = 4'b0100;
        tick();
        check_eq("st_rsp_done", bus.rsp_valid, 4'b0000);
        check_eq("to_err_sticky", bus.err_timeout, 1'b1);
        bus.rsp_ready = 4'b0000;

        // Asynchronous reset clears sticky errors immediately
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_errs", {bus.err_timeout, bus.err_unexpected}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares one MemoryBus request/response slot pair between NUM_REQ requesters (cores, fetch units, DMA), identified by BusID 0..NUM_REQ-1.
- Round-robin grants one requester at a time, writes its packet into the bus request slot and, for reads, holds the grant until the matching read_response is popped and delivered back.
- At most one transaction is in flight; the memory side is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, BusID width (>= clog2(NUM_REQ))
- ADDR_W, 32, memory_address_t width
- DATA_W, 32, bus_packet_payload_t width
- TIMEOUT, 255, max cycles in WAIT_RESP before error (8-bit counter)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_write  in  NUM_REQ  1=write_data, 0=read_data
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write payloads
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot read-data valid
- rsp_data  out  DATA_W  read payload, shared by all requesters
- rsp_ready  in  NUM_REQ  per-requester response accept
- bus_request_busy  in  1  bus request slot occupied
- bus_req_push  out  1  one-cycle write of the request slot
- bus_req_type  out  2  0=read_data, 1=write_data
- bus_req_source  out  ID_W  BusID of the granted requester
- bus_req_addr  out  ADDR_W  request address
- bus_req_payload  out  DATA_W  write payload (0 for reads)
- bus_response_busy  in  1  response slot full
- bus_rsp_type  in  2  must be 2 (read_response)
- bus_rsp_source  in  ID_W  responder source (not checked)
- bus_rsp_payload  in  DATA_W  read data
- bus_rsp_pop  out  1  one-cycle clear of the response slot
- err_timeout  out  1  sticky
- err_unexpected  out  1  sticky

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rr_ptr=0, all outputs 0, counters 0, sticky errors cleared.
- States: IDLE, ISSUE, WAIT_RESP, DELIVER.
- IDLE:
  - If any req_valid, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr itself has highest priority).
  - Latch grant index g, type, addr, wdata; go to ISSUE. No output change this cycle.
- ISSUE:
  - If bus_request_busy=1, stall in ISSUE with outputs unchanged.
  - Else for one cycle: bus_req_push=1 with latched fields, bus_req_source=g, req_ready[g]=1.
  - Write: go to IDLE, rr_ptr=(g+1) mod NUM_REQ.
  - Read: go to WAIT_RESP, timeout counter=0.
  - Requester sees request-to-req_ready latency of 2 cycles minimum; it holds req_valid and fields until req_ready.
- WAIT_RESP:
  - When bus_response_busy=1 and bus_rsp_type=2: bus_rsp_pop=1 for one cycle, latch payload into rsp_data, go to DELIVER.
  - When bus_response_busy=1 and type!=2: pop, set err_unexpected, stay.
  - Counter increments each cycle. On reaching TIMEOUT: set err_timeout, go to IDLE, advance rr_ptr, deliver nothing.
- DELIVER:
  - rsp_valid[g]=1 and rsp_data held until rsp_ready[g]=1 (same-cycle accept).
  - Then rsp_valid=0, go to IDLE, rr_ptr=(g+1) mod NUM_REQ.
- Outside WAIT_RESP, bus_response_busy=1 is ignored: no pop, no error.
- A requester dropping req_valid before req_ready has no effect; the latched request completes.
- rr_ptr wraps NUM_REQ-1 -> 0. A single active requester can be granted back-to-back, one transaction per IDLE visit.
- bus_req_push and bus_rsp_pop are never asserted in the same cycle.
- Reset mid-transaction returns to IDLE immediately. Any packet already in the bus slots is not cleared by this block.

Test Plan:
- Single write: req_valid[1]=1, write, addr=0x100, wdata=0xDEAD, bus free -> push on cycle 2 with type=1, source=1, addr=0x100, payload=0xDEAD; req_ready[1] same cycle; back to IDLE on cycle 3.
- Read round trip: req 2 reads 0x40; response 3 cycles after push with payload 0x1234 -> bus_rsp_pop pulse; rsp_valid[2]=1, rsp_data=0x1234 until rsp_ready[2].
- Fairness: all four requesters writing continuously -> grant order 0,1,2,3,0,1; no requester waits more than 3 grants.
- Backpressure: bus_request_busy=1 for 5 cycles during ISSUE -> no push, req_ready stays 0; push occurs on the first cycle busy=0.
- Timeout: read with no response, TIMEOUT=8 -> err_timeout=1 after 8 WAIT_RESP cycles, arbiter returns to IDLE and grants the next requester.
- Stray response: bus_response_busy=1, type=1 in WAIT_RESP -> pop, err_unexpected=1, still waiting; valid response afterwards delivered normally.
